reg_file_ctrl: RTL
==================

REG_FILE_CTRL -- requirements
Module: reg_file_ctrl

Interface
REQ-001 SHALL have ports: CLKb  in  1  system clock; all state updates on falling edge.
REQ-002 SHALL have port: RSTb  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have port: Execute  in  1  start request; sampled only in IDLE.
REQ-004 SHALL have port: Instr  in  10  instruction; [9:6] opcode, [5:3] Rx, [2:0] Ry.
REQ-005 SHALL have ports: WRA, RDA0, RDA1  out  3 each  register-file write / read-port-0 / read-port-1 addresses.
REQ-006 SHALL have ports: ENW, ENR0, ENR1  out  1 each  register-file write / read-port-0 / read-port-1 enables.
REQ-007 SHALL have ports: LDA  out  1  latch ALU operand A; LDG  out  1  latch ALU result G; FN  out  3  ALU function.
REQ-008 SHALL have ports: GOUT  out  1  drive G onto data bus; EXTRN  out  1  drive external data onto bus.
REQ-009 SHALL have ports: Busy  out  1  instruction in progress; Done  out  1  one-cycle completion pulse; Err  out  1  one-cycle illegal-opcode pulse.

Function
REQ-010 SHALL implement states IDLE, T1, T2, T3, FIN; state register and IR (10 bit) update on negedge CLKb.
REQ-011 IDLE: Execute=1 SHALL latch Instr into IR and enter T1; Execute=0 stays IDLE.
REQ-012 Execute SHALL be ignored in every state other than IDLE; IR SHALL hold stable T1..FIN.
REQ-013 Control outputs SHALL be combinational decodes of (state, IR); all enables, LDA/LDG/GOUT/EXTRN = 0, addresses = 0, FN = 000 whenever not explicitly asserted below.
REQ-014 Opcode 0000 LOAD: T1 -> EXTRN=1, ENW=1, WRA=Rx; then FIN.
REQ-015 Opcode 0001 MOVE: T1 -> ENR0=1, RDA0=Ry, ENW=1, WRA=Rx; then FIN.
REQ-016 Opcodes 0010 ADD, 0011 SUB, 0100 AND, 0101 OR, 0110 XOR: T1 -> ENR0=1, RDA0=Rx, LDA=1; T2 -> ENR1=1, RDA1=Ry, FN=opcode[2:0], LDG=1; T3 -> GOUT=1, ENW=1, WRA=Rx; then FIN.
REQ-017 Opcode 0111 NOT: T1 -> ENR0=1, RDA0=Ry, LDA=1; T2 -> FN=111, LDG=1, no read enable; T3 -> GOUT=1, ENW=1, WRA=Rx; then FIN.
REQ-018 Opcodes 1000-1111 SHALL be illegal: T1 asserts no enables; then FIN with Err=1.
REQ-019 FIN: Done=1 for exactly one cycle (Err=1 too if illegal); next state IDLE unconditionally.
REQ-020 Busy SHALL be 1 in T1, T2, T3, FIN; 0 in IDLE.
REQ-021 Latency Execute-sample to Done: LOAD/MOVE/illegal 2 cycles, ALU ops 4 cycles; back-to-back Execute accepted the cycle after FIN.
REQ-022 At most one of ENW-source (EXTRN, ENR0-as-source, GOUT) SHALL drive the bus in any cycle; ENW never asserted in the same cycle as LDA or LDG.
REQ-023 Rx = Ry SHALL be legal for all ops (e.g. ADD R3,R3 doubles R3); no special casing.

Reset
REQ-024 RSTb=0 SHALL immediately (asynchronously) force state IDLE and IR=0; all outputs 0 including Busy, Done, Err.
REQ-025 Reset mid-instruction SHALL abort with no further ENW; after RSTb release first negedge with Execute=1 starts a new instruction normally.

Verification
REQ-026 Reset then Execute with Instr=0000_101_000 (LOAD R5) -> next cycle EXTRN=1, ENW=1, WRA=5; following cycle Done=1, Busy=0 after.
REQ-027 Instr=0010_011_110 (ADD R3,R6) -> T1 ENR0/RDA0=3/LDA; T2 ENR1/RDA1=6/FN=010/LDG; T3 GOUT/ENW/WRA=3; FIN Done=1; total 4 cycles.
REQ-028 Instr=1010_001_001 -> no ENW/ENR0/ENR1 ever; Done=1 and Err=1 together 2 cycles after start.
REQ-029 Execute held high continuously with MOVE R1<-R2 -> instructions restart every 3 cycles (T1, FIN, IDLE); Instr changes during T1/FIN not reflected in outputs.
REQ-030 RSTb pulsed low during T2 of XOR -> all outputs 0 immediately, no ENW pulse, state IDLE on release.
REQ-031 Instr=0111_100_010 (NOT R4<-~R2) -> T1 RDA0=2/LDA, T2 FN=111/LDG with ENR1=0, T3 ENW WRA=4.

Source files
------------

// File: rtl/reg_file_ctrl.sv
// Instruction sequencer for a register-file/ALU datapath.
// State and IR advance on the falling edge of CLKb; control outputs decode (state, IR).
module reg_file_ctrl (
  input  logic       CLKb,
  input  logic       RSTb,
  input  logic       Execute,
  input  logic [9:0] Instr,
  output logic [2:0] WRA,
  output logic [2:0] RDA0,
  output logic [2:0] RDA1,
  output logic       ENW,
  output logic       ENR0,
  output logic       ENR1,
  output logic       LDA,
  output logic       LDG,
  output logic [2:0] FN,
  output logic       GOUT,
  output logic       EXTRN,
  output logic       Busy,
  output logic       Done,
  output logic       Err
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_T1   = 3'd1,
    S_T2   = 3'd2,
    S_T3   = 3'd3,
    S_FIN  = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [9:0]  r_ir;
  logic [3:0]  w_op;
  logic [2:0]  w_rx;
  logic [2:0]  w_ry;
  logic        w_illegal;
  logic        w_alu_path;

  assign w_op       = r_ir[9:6];
  assign w_rx       = r_ir[5:3];
  assign w_ry       = r_ir[2:0];
  assign w_illegal  = w_op[3];
  // Opcodes 2..7 go through the ALU (T2/T3); 0, 1 and illegal finish after T1.
  assign w_alu_path = ~w_op[3] & (w_op[2] | w_op[1]);

  always_ff @(negedge CLKb or negedge RSTb) begin
    if (!RSTb) begin
      r_state <= S_IDLE;
      r_ir    <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && Execute) begin
        r_ir <= Instr;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    WRA    = '0;
    RDA0   = '0;
    RDA1   = '0;
    ENW    = 1'b0;
    ENR0   = 1'b0;
    ENR1   = 1'b0;
    LDA    = 1'b0;
    LDG    = 1'b0;
    FN     = '0;
    GOUT   = 1'b0;
    EXTRN  = 1'b0;
    Busy   = 1'b0;
    Done   = 1'b0;
    Err    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (Execute) begin
          w_next = S_T1;
        end
      end
      S_T1: begin
        Busy   = 1'b1;
        w_next = w_alu_path ? S_T2 : S_FIN;
        case (w_op)
          4'd0: begin
            EXTRN = 1'b1;
            ENW   = 1'b1;
            WRA   = w_rx;
          end
          4'd1: begin
            ENR0 = 1'b1;
            RDA0 = w_ry;
            ENW  = 1'b1;
            WRA  = w_rx;
          end
          4'd2, 4'd3, 4'd4, 4'd5, 4'd6: begin
            ENR0 = 1'b1;
            RDA0 = w_rx;
            LDA  = 1'b1;
          end
          4'd7: begin
            ENR0 = 1'b1;
            RDA0 = w_ry;
            LDA  = 1'b1;
          end
          default: ;
        endcase
      end
      S_T2: begin
        Busy   = 1'b1;
        w_next = S_T3;
        LDG    = 1'b1;
        FN     = w_op[2:0];
        // NOT is unary: operand already sits in A, so port 1 stays idle.
        if (w_op != 4'd7) begin
          ENR1 = 1'b1;
          RDA1 = w_ry;
        end
      end
      S_T3: begin
        Busy   = 1'b1;
        w_next = S_FIN;
        GOUT   = 1'b1;
        ENW    = 1'b1;
        WRA    = w_rx;
      end
      S_FIN: begin
        Busy   = 1'b1;
        Done   = 1'b1;
        Err    = w_illegal;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

endmodule
